// File: rtl/bsg_cycle_stamp_fifo_if.sv
// bsg_cycle_stamp_fifo_if: event capture, valid/yumi drain and drop-status signals of the cycle stamp FIFO
// slave: the FIFO itself; master: the event source, trace sink and status reader
interface bsg_cycle_stamp_fifo_if #(
  parameter int width_p = 32,
  parameter int tag_width_p = 4,
  parameter int els_p = 8,
  parameter int drop_width_p = 16
);
  logic [width_p-1:0] ctr_i;
  logic event_v_i;
  logic [tag_width_p-1:0] event_tag_i;
  logic v_o;
  logic [tag_width_p+width_p-1:0] data_o;
  logic yumi_i;
  logic [$clog2(els_p+1)-1:0] count_o;
  logic [drop_width_p-1:0] drop_cnt_o;
  logic drop_v_o;
  logic [width_p-1:0] drop_stamp_o;
  logic clear_drop_i;
  modport slave (
    input ctr_i, event_v_i, event_tag_i, yumi_i, clear_drop_i,
    output v_o, data_o, count_o, drop_cnt_o, drop_v_o, drop_stamp_o
  );
  modport master (
    output ctr_i, event_v_i, event_tag_i, yumi_i, clear_drop_i,
    input v_o, data_o, count_o, drop_cnt_o, drop_v_o, drop_stamp_o
  );
endinterface

// File: rtl/bsg_cycle_stamp_fifo.sv
// bsg_cycle_stamp_fifo: timestamps event pulses with ctr_i into a FIFO drained by valid/yumi, counting and stamping drops
// clk_i, reset_i (async, active-high); io: capture (ctr_i, event_v_i, event_tag_i), drain (v_o, data_o, yumi_i),
// status (count_o, drop_cnt_o, drop_v_o, drop_stamp_o, clear_drop_i)
module bsg_cycle_stamp_fifo #(
  parameter int width_p = 32,
  parameter int tag_width_p = 4,
  parameter int els_p = 8,
  parameter int drop_width_p = 16
) (
  input logic clk_i,
  input logic reset_i,
  bsg_cycle_stamp_fifo_if.slave io
);
  localparam int aw = $clog2(els_p);
  localparam int cw = $clog2(els_p+1);
  logic [tag_width_p+width_p-1:0] mem [els_p];
  logic [aw-1:0] rptr, wptr;
  logic [cw-1:0] cnt;
  logic [drop_width_p-1:0] drop_cnt;
  logic drop_v;
  logic [width_p-1:0] drop_stamp;
  logic full, enq, drop;
  always_comb begin
    full = cnt == cw'(els_p);
    // a same-cycle pop frees the slot, so a full FIFO still accepts when yumi_i is high
    enq = io.event_v_i & (~full | io.yumi_i);
    drop = io.event_v_i & full & ~io.yumi_i;
  end
  always_ff @(posedge clk_i) if (enq) mem[wptr] <= {io.event_tag_i, io.ctr_i};
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt <= '0;
      drop_cnt <= '0;
      drop_v <= 1'b0;
      drop_stamp <= '0;
    end else begin
      rptr <= rptr + aw'(io.yumi_i);
      wptr <= wptr + aw'(enq);
      cnt <= cnt + cw'(enq) - cw'(io.yumi_i);
      // clear beats a simultaneous drop, which then starts a fresh record
      drop_cnt <= io.clear_drop_i ? drop_width_p'(drop) : drop_cnt + drop_width_p'(drop & ~&drop_cnt);
      drop_v <= io.clear_drop_i ? drop : drop_v | drop;
      drop_stamp <= drop & (io.clear_drop_i | ~drop_v) ? io.ctr_i : io.clear_drop_i ? '0 : drop_stamp;
    end
  assign io.v_o = cnt != '0;
  assign io.data_o = mem[rptr];
  assign io.count_o = cnt;
  assign io.drop_cnt_o = drop_cnt;
  assign io.drop_v_o = drop_v;
  assign io.drop_stamp_o = drop_stamp;
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) io.yumi_i |-> io.v_o);
endmodule

// File: tb/tb_bsg_cycle_stamp_fifo.sv
// tb_bsg_cycle_stamp_fifo: directed self-checking bench for bsg_cycle_stamp_fifo
module tb_bsg_cycle_stamp_fifo;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int errors = 0;
  int checks = 0;
  bsg_cycle_stamp_fifo_if #(.width_p(32), .tag_width_p(4), .els_p(8), .drop_width_p(16)) bus ();
  bsg_cycle_stamp_fifo #(.width_p(32), .tag_width_p(4), .els_p(8), .drop_width_p(16)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .io(bus.slave)
  );
  always #5 clk_i = ~clk_i;
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pop();
    bus.yumi_i = 1'b1;
    step();
    bus.yumi_i = 1'b0;
  endtask
  initial begin
    bus.ctr_i = '0;
    bus.event_v_i = 1'b0;
    bus.event_tag_i = '0;
    bus.yumi_i = 1'b0;
    bus.clear_drop_i = 1'b0;
    #12 reset_i = 1'b0;
    check("rst_v", 64'(bus.v_o), 64'd0);
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_drop_cnt", 64'(bus.drop_cnt_o), 64'd0);
    check("rst_drop_v", 64'(bus.drop_v_o), 64'd0);
    check("rst_drop_stamp", 64'(bus.drop_stamp_o), 64'd0);
    // single event
    bus.ctr_i = 100;
    bus.event_v_i = 1'b1;
    bus.event_tag_i = 4'd3;
    step();
    bus.event_v_i = 1'b0;
    check("t1_v", 64'(bus.v_o), 64'd1);
    check("t1_data", 64'(bus.data_o), {28'd0, 4'd3, 32'd100});
    check("t1_count", 64'(bus.count_o), 64'd1);
    pop();
    check("t1_empty", 64'(bus.count_o), 64'd0);
    // fill, then overflow
    for (int i = 0; i < 8; i++) begin
      bus.ctr_i = 32'(10 + i);
      bus.event_v_i = 1'b1;
      bus.event_tag_i = 4'(i);
      step();
    end
    check("t2_full", 64'(bus.count_o), 64'd8);
    bus.ctr_i = 18;
    bus.event_tag_i = 4'd15;
    step();
    bus.event_v_i = 1'b0;
    check("t2_count", 64'(bus.count_o), 64'd8);
    check("t2_drop_cnt", 64'(bus.drop_cnt_o), 64'd1);
    check("t2_drop_v", 64'(bus.drop_v_o), 64'd1);
    check("t2_drop_stamp", 64'(bus.drop_stamp_o), 64'd18);
    check("t2_head", 64'(bus.data_o), {28'd0, 4'd0, 32'd10});
    // full with simultaneous pop accepts
    bus.ctr_i = 30;
    bus.event_v_i = 1'b1;
    bus.event_tag_i = 4'd9;
    bus.yumi_i = 1'b1;
    step();
    bus.event_v_i = 1'b0;
    bus.yumi_i = 1'b0;
    check("t3_count", 64'(bus.count_o), 64'd8);
    check("t3_drop_cnt", 64'(bus.drop_cnt_o), 64'd1);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("t3_drain%0d", i), 64'(bus.data_o), {28'd0, 4'(i), 32'(10 + i)});
      pop();
    end
    check("t3_last", 64'(bus.data_o), {28'd0, 4'd9, 32'd30});
    pop();
    check("t3_empty_v", 64'(bus.v_o), 64'd0);
    // saturate the drop counter
    for (int i = 0; i < 8; i++) begin
      bus.ctr_i = 32'(40 + i);
      bus.event_v_i = 1'b1;
      bus.event_tag_i = 4'd5;
      step();
    end
    bus.ctr_i = 60;
    for (int i = 0; i < 65534; i++) step();
    check("t4_sat", 64'(bus.drop_cnt_o), 64'hFFFF);
    check("t4_stamp_kept", 64'(bus.drop_stamp_o), 64'd18);
    step();
    check("t4_no_wrap", 64'(bus.drop_cnt_o), 64'hFFFF);
    bus.event_v_i = 1'b0;
    bus.clear_drop_i = 1'b1;
    step();
    bus.clear_drop_i = 1'b0;
    check("t4_clr_cnt", 64'(bus.drop_cnt_o), 64'd0);
    check("t4_clr_v", 64'(bus.drop_v_o), 64'd0);
    check("t4_clr_stamp", 64'(bus.drop_stamp_o), 64'd0);
    check("t4_count", 64'(bus.count_o), 64'd8);
    // clear with simultaneous drop
    bus.ctr_i = 500;
    bus.event_v_i = 1'b1;
    bus.clear_drop_i = 1'b1;
    step();
    bus.event_v_i = 1'b0;
    bus.clear_drop_i = 1'b0;
    check("t5_cnt", 64'(bus.drop_cnt_o), 64'd1);
    check("t5_v", 64'(bus.drop_v_o), 64'd1);
    check("t5_stamp", 64'(bus.drop_stamp_o), 64'd500);
    // async reset with 5 queued, then counter wrap
    for (int i = 0; i < 3; i++) pop();
    check("t6_five", 64'(bus.count_o), 64'd5);
    #2 reset_i = 1'b1;
    #1;
    check("t6_rst_v", 64'(bus.v_o), 64'd0);
    check("t6_rst_count", 64'(bus.count_o), 64'd0);
    check("t6_rst_drop_v", 64'(bus.drop_v_o), 64'd0);
    check("t6_rst_drop_cnt", 64'(bus.drop_cnt_o), 64'd0);
    #1 reset_i = 1'b0;
    bus.ctr_i = 32'hFFFF_FFFF;
    bus.event_v_i = 1'b1;
    bus.event_tag_i = 4'd1;
    step();
    bus.ctr_i = 32'd0;
    bus.event_tag_i = 4'd2;
    step();
    bus.event_v_i = 1'b0;
    check("t6_count", 64'(bus.count_o), 64'd2);
    check("t6_wrap_hi", 64'(bus.data_o), {28'd0, 4'd1, 32'hFFFF_FFFF});
    pop();
    check("t6_wrap_lo", 64'(bus.data_o), {28'd0, 4'd2, 32'd0});
    pop();
    check("t6_end", 64'(bus.count_o), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
